ddr_axi_burst_tester: RTL and testbench

//  Parametrised DDR write/read-back traffic generator and checker on an AXI-style master port.

---
 rtl/ddr_test_pkg.sv | 29 ++
 rtl/ddr_test_pattern_gen.sv | 13 +
 rtl/ddr_axi_burst_tester.sv | 276 +++++++++++++++++++++++++++
 tb/tb_ddr_axi_burst_tester.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_test_pkg.sv
// Shared FSM state type, counter width and data pattern for the DDR burst self-test master.
package ddr_test_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_BURST,
    S_WR_RESP,
    S_RD_BURST,
    S_RD_DATA,
    S_DONE
  } state_t;

  localparam int CNT_W     = 16;
  localparam int PAT_MAX_W = 512;

  // Lane j of beat b in burst n; lanes at or above data_w are left zero.
  function automatic logic [PAT_MAX_W-1:0] ddr_test_pattern(
    input logic [11:0] n,
    input logic [7:0]  b,
    input int          data_w,
    input logic [31:0] seed
  );
    logic [PAT_MAX_W-1:0] p;
    p = '0;
    for (int j = 0; j < PAT_MAX_W / 32; j++) begin
      if (j < data_w / 32) p[j*32 +: 32] = seed ^ {n, b, 4'(j), 8'h5A};
    end
    return p;
  endfunction
endpackage

// File: rtl/ddr_test_pattern_gen.sv
// Combinational beat pattern for a given (burst, beat) position.
module ddr_test_pattern_gen
  import ddr_test_pkg::*;
#(
  parameter int          DATA_W = 128,
  parameter logic [31:0] SEED   = 32'hA5A5_0000
) (
  input  logic [11:0]       burst_idx,
  input  logic [7:0]        beat_idx,
  output logic [DATA_W-1:0] pattern
);
  always_comb pattern = DATA_W'(ddr_test_pattern(burst_idx, beat_idx, DATA_W, SEED));
endmodule

// File: rtl/ddr_axi_burst_tester.sv
// DDR write/read-back burst traffic generator and checker on an AXI-style master port.
// Optional first-error capture ports are enabled by defining DDR_TEST_ERR_LOG_EN.
module ddr_axi_burst_tester
  import ddr_test_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 128,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h0000_F000,
  parameter int                BURST_LEN  = 4,
  parameter int                NUM_BURSTS = 8,
  parameter logic [31:0]       SEED       = 32'hA5A5_0000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                ddr_ready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    err_cnt,
  output state_t              dbg_state
`ifdef DDR_TEST_ERR_LOG_EN
  ,
  output logic                err_valid,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [DATA_W-1:0]   err_exp,
  output logic [DATA_W-1:0]   err_act
`endif
);
  // Handshake rule: a beat moves on a rising edge where valid and ready are both high;
  // every master valid and its payload are held unchanged while valid is high and ready is low.
  localparam logic [7:0]       LEN_M1      = 8'(BURST_LEN - 1);
  localparam logic [8:0]       LAST_BEAT   = 9'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_BURST  = CNT_W'(NUM_BURSTS - 1);
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * (DATA_W / 8));

  state_t           state_q, state_d;
  logic [CNT_W-1:0] burst_q, burst_d, err_cnt_q, err_cnt_d;
  logic [8:0]       beat_q, beat_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic             arvalid_q, arvalid_d, rready_q, rready_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ADDR_W-1:0] burst_addr;
  logic [DATA_W-1:0] wr_pattern, rd_expected;
  logic             aw_fire, w_fire, last_beat, beat_err;

  ddr_test_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_pat (
    .burst_idx(burst_q[11:0]), .beat_idx(beat_q[7:0]), .pattern(wr_pattern)
  );
  ddr_test_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_rd_pat (
    .burst_idx(burst_q[11:0]), .beat_idx(beat_q[7:0]), .pattern(rd_expected)
  );

  assign burst_addr = BASE_ADDR + ADDR_W'(burst_q) * BURST_BYTES;
  assign aw_fire    = awvalid_q & awready;
  assign w_fire     = wvalid_q & wready;
  assign last_beat  = (beat_q == LAST_BEAT);
  assign beat_err   = (rdata != rd_expected) || (rlast != last_beat);

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    err_cnt_d = err_cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start && ddr_ready) begin
          state_d   = S_WR_BURST;
          burst_d   = '0;
          beat_d    = '0;
          err_cnt_d = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end
      end
      S_WR_BURST: begin
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          if (last_beat) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
            beat_d   = '0;
          end else begin
            beat_d = beat_q + 9'd1;
          end
        end
        // AW and the last W beat may complete in either order or together.
        if ((aw_done_q || aw_fire) && (w_done_q || (w_fire && last_beat))) begin
          state_d   = S_WR_RESP;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_WR_RESP: begin
        if (bvalid) begin
          bready_d = 1'b0;
          if (burst_q == LAST_BURST) begin
            burst_d   = '0;
            arvalid_d = 1'b1;
            state_d   = S_RD_BURST;
          end else begin
            burst_d   = burst_q + 1'b1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_BURST;
          end
        end
      end
      S_RD_BURST: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          beat_d    = '0;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (rvalid) begin
          if (beat_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
          if (rlast) begin
            rready_d = 1'b0;
            beat_d   = '0;
            if (burst_q == LAST_BURST) begin
              burst_d = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_cnt_d == '0);
              state_d = S_DONE;
            end else begin
              burst_d   = burst_q + 1'b1;
              arvalid_d = 1'b1;
              state_d   = S_RD_BURST;
            end
          end else begin
            beat_d = beat_q + 9'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DDR_TEST_ERR_LOG_EN
  logic              err_valid_q, err_valid_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [DATA_W-1:0] err_exp_q, err_exp_d, err_act_q, err_act_d;

  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_exp_d   = err_exp_q;
    err_act_d   = err_act_q;
    if (state_q == S_IDLE && start && ddr_ready) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
      err_exp_d   = '0;
      err_act_d   = '0;
    end else if (state_q == S_RD_DATA && rvalid && beat_err && !err_valid_q) begin
      err_valid_d = 1'b1;
      err_addr_d  = burst_addr + ADDR_W'(beat_q) * BEAT_BYTES;
      err_exp_d   = rd_expected;
      err_act_d   = rdata;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_exp   = err_exp_q;
  assign err_act   = err_act_q;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      burst_q   <= '0;
      beat_q    <= '0;
      err_cnt_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
`ifdef DDR_TEST_ERR_LOG_EN
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_exp_q   <= '0;
      err_act_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_cnt_q <= err_cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
`ifdef DDR_TEST_ERR_LOG_EN
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_exp_q   <= err_exp_d;
      err_act_q   <= err_act_d;
`endif
    end
  end

  assign awaddr    = burst_addr;
  assign awlen     = LEN_M1;
  assign awvalid   = awvalid_q;
  assign wdata     = wr_pattern;
  assign wstrb     = '1;
  assign wlast     = wvalid_q & last_beat;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = burst_addr;
  assign arlen     = LEN_M1;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_ddr_axi_burst_tester.sv
// Bench for ddr_axi_burst_tester: a reactive memory slave, scenario table and corner sequences.
`timescale 1ns/1ps
module tb_ddr_axi_burst_tester;
  import ddr_test_pkg::*;

  localparam logic [31:0] SEED = 32'hA5A5_0000;
  localparam logic [31:0] BASE = 32'h0000_F000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (defaults) ----------------
  logic start = 1'b0, ddr_ready = 1'b1;
  logic [31:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, arvalid, arready;
  logic [127:0] wdata, rdata;
  logic [15:0] wstrb, err_cnt;
  logic rlast, rvalid, rready, busy, done, pass;
  state_t dbg_state;
`ifdef DDR_TEST_ERR_LOG_EN
  logic err_valid;
  logic [31:0] err_addr;
  logic [127:0] err_exp, err_act;
`endif

  ddr_axi_burst_tester u_dut (
    .clk(clk), .rstn(rstn), .start(start), .ddr_ready(ddr_ready),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .dbg_state(dbg_state)
`ifdef DDR_TEST_ERR_LOG_EN
    , .err_valid(err_valid), .err_addr(err_addr), .err_exp(err_exp), .err_act(err_act)
`endif
  );

  // ---------------- second DUT: single-beat, single-burst ----------------
  logic start1 = 1'b0;
  logic [31:0] awaddr1, araddr1;
  logic [7:0] awlen1, arlen1;
  logic awvalid1, awready1, wlast1, wvalid1, wready1, bvalid1, bready1, arvalid1, arready1;
  logic [127:0] wdata1, rdata1;
  logic [15:0] wstrb1, err_cnt1;
  logic rlast1, rvalid1, rready1, busy1, done1, pass1;
  state_t dbg_state1;
`ifdef DDR_TEST_ERR_LOG_EN
  logic err_valid1;
  logic [31:0] err_addr1;
  logic [127:0] err_exp1, err_act1;
`endif

  ddr_axi_burst_tester #(.BURST_LEN(1), .NUM_BURSTS(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .ddr_ready(1'b1),
    .awaddr(awaddr1), .awlen(awlen1), .awvalid(awvalid1), .awready(awready1),
    .wdata(wdata1), .wstrb(wstrb1), .wlast(wlast1), .wvalid(wvalid1), .wready(wready1),
    .bvalid(bvalid1), .bready(bready1),
    .araddr(araddr1), .arlen(arlen1), .arvalid(arvalid1), .arready(arready1),
    .rdata(rdata1), .rlast(rlast1), .rvalid(rvalid1), .rready(rready1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1), .dbg_state(dbg_state1)
`ifdef DDR_TEST_ERR_LOG_EN
    , .err_valid(err_valid1), .err_addr(err_addr1), .err_exp(err_exp1), .err_act(err_act1)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] exp_beat(input int n, input int b);
    logic [127:0] p;
    for (int j = 0; j < 4; j++) p[j*32 +: 32] = SEED ^ {n[11:0], b[7:0], j[3:0], 8'h5A};
    return p;
  endfunction

  // ---------------- slave knobs and scoreboard state ----------------
  logic inject_err = 1'b0, stall = 1'b0, aw_delay = 1'b0, early_rlast = 1'b0, model_clr = 1'b0;
  int aw_cnt, w_total, w_beat, w_bursts, b_cnt, ar_cnt, r_beats, r_beat, r_burst, aw_wait;
  logic [31:0] ar_q[$];
  logic [127:0] exp_q[$];
  logic [127:0] mem[logic [31:0]];
  logic w_stall_prev;
  logic [127:0] prev_wdata;

  // Main slave: decides its outputs at each falling edge, then books the transfers the next rising edge performs.
  initial forever begin
    @(negedge clk);
    if (!rstn || model_clr) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0; rdata = '0;
      aw_cnt = 0; w_total = 0; w_beat = 0; w_bursts = 0; b_cnt = 0; ar_cnt = 0;
      r_beats = 0; r_beat = 0; r_burst = 0; aw_wait = 0; w_stall_prev = 0;
      ar_q.delete();
      if (model_clr) begin
        exp_q.delete();
        for (int n = 0; n < 8; n++) for (int b = 0; b < 4; b++) exp_q.push_back(exp_beat(n, b));
      end
    end else begin
      if (w_stall_prev) begin
        check("w_hold_valid", wvalid, 1'b1);
        check("w_hold_data", wdata, prev_wdata);
      end
      if (awvalid && (w_bursts > aw_cnt)) aw_wait++;
      awready = aw_delay ? (aw_wait >= 5) : 1'b1;
      wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid  = (aw_cnt > b_cnt) && (w_bursts > b_cnt);
      arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ar_q.size() > 0) begin
        logic [31:0] ra;
        ra = ar_q[0] + 32'(r_beat * 16);
        rvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        rdata  = mem.exists(ra) ? mem[ra] : '0;
        if (inject_err && r_burst == 2 && r_beat == 1) rdata[0] = ~rdata[0];
        rlast  = (r_beat == 3) || (early_rlast && r_burst == 0 && r_beat == 1);
      end else begin
        rvalid = 0;
        rlast  = 0;
      end

      if (awvalid && awready) begin
        check("awaddr", awaddr, 32'(BASE + 32'(aw_cnt * 64)));
        check("awlen", awlen, 8'd3);
        aw_cnt++;
        aw_wait = 0;
      end
      if (wvalid && wready) begin
        if (exp_q.size() == 0) check("w_extra_beat", 1'b1, 1'b0);
        else check("wdata", wdata, exp_q.pop_front());
        check("wlast", wlast, w_beat == 3);
        check("wstrb", wstrb, 16'hFFFF);
        mem[BASE + 32'(w_bursts * 64 + w_beat * 16)] = wdata;
        w_total++;
        if (w_beat == 3) begin
          w_beat = 0;
          w_bursts++;
        end else w_beat++;
      end
      if (bvalid && bready) b_cnt++;
      if (arvalid && arready) begin
        check("araddr", araddr, 32'(BASE + 32'(ar_cnt * 64)));
        check("arlen", arlen, 8'd3);
        ar_q.push_back(araddr);
        ar_cnt++;
      end
      if (rvalid && rready) begin
        r_beats++;
        if (rlast) begin
          void'(ar_q.pop_front());
          r_beat = 0;
          r_burst++;
        end else r_beat++;
      end
      w_stall_prev = wvalid && !wready;
      prev_wdata   = wdata;
    end
  end

  // Single-beat slave for the second instance.
  int aw1_cnt, w1_cnt, b1_cnt, ar1_cnt, r1_cnt;
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      awready1 = 0; wready1 = 0; bvalid1 = 0; arready1 = 0; rvalid1 = 0; rlast1 = 0; rdata1 = '0;
      aw1_cnt = 0; w1_cnt = 0; b1_cnt = 0; ar1_cnt = 0; r1_cnt = 0;
    end else begin
      awready1 = 1; wready1 = 1; arready1 = 1;
      bvalid1 = (aw1_cnt > b1_cnt) && (w1_cnt > b1_cnt);
      rvalid1 = (ar1_cnt > r1_cnt);
      rdata1  = exp_beat(0, 0);
      rlast1  = 1;
      if (awvalid1) begin
        check("awaddr1", awaddr1, BASE);
        check("awlen1", awlen1, 8'd0);
        aw1_cnt++;
      end
      if (wvalid1) begin
        check("wlast1", wlast1, 1'b1);
        check("wdata1", wdata1, exp_beat(0, 0));
        w1_cnt++;
      end
      if (bvalid1 && bready1) b1_cnt++;
      if (arvalid1) begin
        check("araddr1", araddr1, BASE);
        check("arlen1", arlen1, 8'd0);
        ar1_cnt++;
      end
      if (rvalid1 && rready1) r1_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    tick();
    model_clr = 1; start = 1;
    tick();
    model_clr = 0; start = 0;
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 6000 && !done; c++) tick();
    check({name, "_done_in_time"}, done, 1'b1);
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    logic inject, stall, aw_delay, early, dup_start, drop_ready;
    logic [15:0] exp_err;
    logic exp_pass;
    int exp_r;
    logic [31:0] exp_err_addr;
    int err_n, err_b;
    logic err_flip;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{0, 0, 0, 0, 1, 0, 16'd0, 1, 32, 32'h0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 0, 0, 16'd1, 0, 32, 32'h0000_F090, 2, 1, 1};
    vecs[2] = '{0, 1, 1, 0, 0, 1, 16'd0, 1, 32, 32'h0, 0, 0, 0};
    vecs[3] = '{0, 0, 0, 1, 0, 0, 16'd1, 0, 30, 32'h0000_F010, 0, 1, 0};
    vecs[4] = '{1, 1, 0, 0, 0, 0, 16'd1, 0, 32, 32'h0000_F090, 2, 1, 1};

    repeat (3) tick();
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err_cnt", err_cnt, 16'd0);
    check("rst_state", dbg_state, S_IDLE);
    rstn = 1;
    tick();

    // start without ddr_ready is ignored
    ddr_ready = 0;
    start_run();
    repeat (3) tick();
    check("noready_busy", busy, 1'b0);
    check("noready_awvalid", awvalid, 1'b0);
    check("noready_state", dbg_state, S_IDLE);
    ddr_ready = 1;

    for (int i = 0; i < 5; i++) begin
      inject_err = vecs[i].inject;
      stall = vecs[i].stall;
      aw_delay = vecs[i].aw_delay;
      early_rlast = vecs[i].early;
      start_run();
      check($sformatf("v%0d_busy_after_start", i), busy, 1'b1);
      check($sformatf("v%0d_done_cleared", i), done, 1'b0);
      if (vecs[i].drop_ready) ddr_ready = 0;
      if (vecs[i].dup_start) begin
        repeat (5) tick();
        start = 1;
        tick();
        start = 0;
      end
      wait_done($sformatf("v%0d", i));
      ddr_ready = 1;
      check($sformatf("v%0d_busy", i), busy, 1'b0);
      check($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
      check($sformatf("v%0d_err_cnt", i), err_cnt, vecs[i].exp_err);
      check($sformatf("v%0d_aw_count", i), 32'(aw_cnt), 32'd8);
      check($sformatf("v%0d_w_count", i), 32'(w_total), 32'd32);
      check($sformatf("v%0d_b_count", i), 32'(b_cnt), 32'd8);
      check($sformatf("v%0d_ar_count", i), 32'(ar_cnt), 32'd8);
      check($sformatf("v%0d_r_count", i), 32'(r_beats), 32'(vecs[i].exp_r));
      check($sformatf("v%0d_exp_q_empty", i), 32'(exp_q.size()), 32'd0);
`ifdef DDR_TEST_ERR_LOG_EN
      check($sformatf("v%0d_err_valid", i), err_valid, vecs[i].exp_err != 0);
      if (vecs[i].exp_err != 0) begin
        check($sformatf("v%0d_err_addr", i), err_addr, vecs[i].exp_err_addr);
        check($sformatf("v%0d_err_exp", i), err_exp, exp_beat(vecs[i].err_n, vecs[i].err_b));
        check($sformatf("v%0d_err_act", i), err_act,
              exp_beat(vecs[i].err_n, vecs[i].err_b) ^ 128'(vecs[i].err_flip));
      end
`endif
      repeat (3) tick();
      check($sformatf("v%0d_done_sticky", i), done, 1'b1);
      check($sformatf("v%0d_state_idle", i), dbg_state, S_IDLE);
    end
    inject_err = 0; stall = 0; aw_delay = 0; early_rlast = 0;

    // asynchronous reset in the middle of the read phase
    start_run();
    for (int c = 0; c < 2000 && !rready; c++) tick();
    check("abort_reached_rd_data", rready, 1'b1);
    rstn = 0;
    #2;
    check("abort_rready", rready, 1'b0);
    check("abort_arvalid", arvalid, 1'b0);
    check("abort_awvalid", awvalid, 1'b0);
    check("abort_wvalid", wvalid, 1'b0);
    check("abort_bready", bready, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_pass", pass, 1'b0);
    check("abort_err_cnt", err_cnt, 16'd0);
    check("abort_state", dbg_state, S_IDLE);
    repeat (2) tick();
    rstn = 1;
    tick();

    // single-beat, single-burst instance
    start1 = 1;
    tick();
    start1 = 0;
    for (int c = 0; c < 500 && !done1; c++) tick();
    check("bl1_done", done1, 1'b1);
    check("bl1_pass", pass1, 1'b1);
    check("bl1_err_cnt", err_cnt1, 16'd0);
    check("bl1_aw_count", 32'(aw1_cnt), 32'd1);
    check("bl1_w_count", 32'(w1_cnt), 32'd1);
    check("bl1_r_count", 32'(r1_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
